wb_cmd_master: RTL and testbench
================================

// Module: wb_cmd_master
// PURPOSE
//  Wishbone classic (B3) initiator. Turns a command (addr, len, we, sel) into len single 32-bit
//  bus transfers with word-address increment, streaming write data in and read data out.
//  Sits between an on-chip sequencer or bench and the CSR/RX-memory Wishbone slave; programs
//  MAC/IP/port CSRs and drains RX memory.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles stb may stay high without ack before abort (1..65535)
//  LEN_W           8    width of cmd_len; max burst = 2**LEN_W-1 beats
// PORTS
//  wb_clk_i     in   1      sole clock, rising edge
//  wb_rst_n_i   in   1      reset, asynchronous assert, active-low
//  cmd_valid    in   1      command offered
//  cmd_ready    out  1      command accepted when valid&ready
//  cmd_we       in   1      1=write burst, 0=read burst
//  cmd_adr      in   32     byte address of first beat
//  cmd_len      in   LEN_W  beat count; 0 = no bus activity
//  cmd_sel      in   4      byte lanes, applied to every beat
//  wdat_valid   in   1      write beat data offered
//  wdat_ready   out  1      write beat taken when valid&ready
//  wdat         in   32     write beat data
//  rdat_valid   out  1      read beat data available
//  rdat_ready   in   1      consumer takes rdat when valid&ready
//  rdat         out  32     read beat data
//  done         out  1      1-cycle pulse: command finished (ok or aborted)
//  err          out  1      1-cycle pulse with done: aborted by timeout
//  wbm_cyc_o    out  1      Wishbone cycle
//  wbm_stb_o    out  1      Wishbone strobe (always equal to wbm_cyc_o)
//  wbm_we_o     out  1      Wishbone write enable
//  wbm_sel_o    out  4      Wishbone byte select
//  wbm_adr_o    out  32     Wishbone address
//  wbm_dat_o    out  32     Wishbone write data
//  wbm_ack_i    in   1      Wishbone acknowledge
//  wbm_dat_i    in   32     Wishbone read data
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0; asserting mid-transfer drops cyc/stb immediately.
//  All outputs registered. FSM states:
//  - IDLE: cmd_ready=1. On accept latch we/adr/sel, beats=cmd_len. len==0 -> done next
//    cycle, stay IDLE. we=1 -> WDATA; we=0 -> BUS.
//  - WDATA: wdat_ready=1. On handshake wbm_dat_o<=wdat, -> BUS.
//  - BUS: cyc=stb=1, adr/we/sel/dat stable until ack. ack -> cyc=stb=0 next cycle (>=1 idle
//    cycle between beats). Read: rdat<=wbm_dat_i, -> RDATA. Write: beats-1, adr+4; last ->
//    IDLE + done; else -> WDATA.
//  - RDATA: rdat_valid=1, rdat stable until rdat_ready. Handshake: beats-1, adr+4; last ->
//    IDLE + done; else -> BUS. Bus idle while consumer stalls.
//  Timeout: counter clears on BUS entry, increments each BUS cycle without ack; reaching
//  TIMEOUT_CYCLES -> cyc/stb low next cycle, done=err=1 one cycle, remaining beats dropped.
//  ack and timeout in same cycle: ack wins, no err.
//  ack outside BUS ignored. Address increments mod 2**32 (0xFFFF_FFFC -> 0x0000_0000).
//  cmd_ready=0 in all states but IDLE; new command cannot be accepted in done cycle.
//  Latency: first stb one cycle after read accept; done one cycle after final ack/handshake.
// STRUCTURE
//  Shared include vthernet_defs.vh: FSM state encodings, CSR address map (MAC low/high,
//  IP, port, src regs, RX_MEM_BASE) so master users and the CSR slave share constants.
//  One sub-module: wb_timeout_cnt (load/enable/expire, width from TIMEOUT_CYCLES).
//  Remainder (FSM, address/beat counters, data regs) flat in this module.
// TESTING (bench pairs DUT with the CSR Wishbone slave; ack not combinational)
//  1 write len=1 adr=0x3000_0000 data=0xDEADBEEF, then read len=1 -> rdat=0xDEADBEEF, err=0.
//  2 read len=4 adr=0x3000_0000 -> rdat 0x5E0000FB,0x00000100,0xE00000FB,port; adr steps +4; 4 cyc pulses.
//  3 rdat_ready low 10 cycles mid-burst -> rdat stable, cyc=0 throughout, burst resumes intact.
//  4 stub slave never acks, TIMEOUT_CYCLES=16 -> stb high exactly 16 cycles, done=err=1, IDLE.
//  5 len=0 -> done one cycle after accept, cyc never asserted; adr=0xFFFF_FFFC len=2 -> 2nd adr 0x0.
//  6 wb_rst_n_i low during BUS of beat 2 of 4 -> cyc/stb/done 0 same cycle; new cmd works after.

Source files
------------

// File: rtl/wb_cmd_master_pkg.sv
// Shared constants for the Wishbone command master and its users: FSM state
// encoding, CSR address map and the word-address step helper.
package wb_cmd_master_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StWdata = 2'd1,
      StBus   = 2'd2,
      StRdata = 2'd3
   } state_e;

   // CSR slave address map, shared with the slave side
   localparam logic [31:0] CsrBase   = 32'h3000_0000;
   localparam logic [31:0] CsrMacLo  = CsrBase + 32'h0000_0000;
   localparam logic [31:0] CsrMacHi  = CsrBase + 32'h0000_0004;
   localparam logic [31:0] CsrIp     = CsrBase + 32'h0000_0008;
   localparam logic [31:0] CsrPort   = CsrBase + 32'h0000_000C;
   localparam logic [31:0] CsrSrcMac = CsrBase + 32'h0000_0010;
   localparam logic [31:0] CsrSrcIp  = CsrBase + 32'h0000_0014;
   localparam logic [31:0] RxMemBase = CsrBase + 32'h0000_1000;

   localparam logic [31:0] AdrStep = 32'd4;

   // Next word address; wraps modulo 2**32
   function automatic logic [31:0] next_adr(input logic [31:0] adr);
      return adr + AdrStep;
   endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Bus-cycle watchdog: counts strobe cycles without acknowledge and flags expiry
// once TIMEOUT_CYCLES such cycles have elapsed.
module wb_timeout_cnt #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expire
);

   localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CntW-1:0] Last = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] cnt_q;

   // Clear while not on the bus, count unacknowledged cycles, hold at the limit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= '0;
      end else if (en && (cnt_q != Last)) begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

   // High during the TIMEOUT_CYCLES-th strobe cycle without ack
   assign expire = (cnt_q == Last);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: expands one (addr, len, we, sel) command into len
// single-word transfers, streaming write data in and read data out.
module wb_cmd_master
   import wb_cmd_master_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned LEN_W          = 8
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_n_i,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_we,
   input  logic [31:0]      cmd_adr,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic [3:0]       cmd_sel,
   input  logic             wdat_valid,
   output logic             wdat_ready,
   input  logic [31:0]      wdat,
   output logic             rdat_valid,
   input  logic             rdat_ready,
   output logic [31:0]      rdat,
   output logic             done,
   output logic             err,
   output logic             wbm_cyc_o,
   output logic             wbm_stb_o,
   output logic             wbm_we_o,
   output logic [3:0]       wbm_sel_o,
   output logic [31:0]      wbm_adr_o,
   output logic [31:0]      wbm_dat_o,
   input  logic             wbm_ack_i,
   input  logic [31:0]      wbm_dat_i
);

   state_e           state_q;
   logic [LEN_W-1:0] beats_q;
   logic [31:0]      adr_q;
   logic [31:0]      dat_q;
   logic [31:0]      rdat_q;
   logic [3:0]       sel_q;
   logic             we_q;
   logic             cyc_q;
   logic             cmd_ready_q;
   logic             wdat_ready_q;
   logic             rdat_valid_q;
   logic             done_q;
   logic             err_q;
   logic             expire;
   logic             last_beat;

   assign last_beat = (beats_q == LEN_W'(1));

   wb_timeout_cnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_n_i),
      .load  (state_q != StBus),
      .en    ((state_q == StBus) && !wbm_ack_i),
      .expire(expire)
   );

   // Command FSM; every output comes straight from a register updated here
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state_q      <= StIdle;
         beats_q      <= '0;
         adr_q        <= '0;
         dat_q        <= '0;
         rdat_q       <= '0;
         sel_q        <= '0;
         we_q         <= 1'b0;
         cyc_q        <= 1'b0;
         cmd_ready_q  <= 1'b0;
         wdat_ready_q <= 1'b0;
         rdat_valid_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (cmd_ready_q && cmd_valid) begin
                  // ready drops for one cycle so a command is never taken in the done cycle
                  cmd_ready_q <= 1'b0;
                  we_q        <= cmd_we;
                  adr_q       <= cmd_adr;
                  sel_q       <= cmd_sel;
                  beats_q     <= cmd_len;
                  if (cmd_len == '0) begin
                     done_q <= 1'b1;
                  end else if (cmd_we) begin
                     state_q      <= StWdata;
                     wdat_ready_q <= 1'b1;
                  end else begin
                     state_q <= StBus;
                     cyc_q   <= 1'b1;
                  end
               end else begin
                  cmd_ready_q <= 1'b1;
               end
            end
            StWdata: begin
               if (wdat_valid) begin
                  dat_q        <= wdat;
                  wdat_ready_q <= 1'b0;
                  cyc_q        <= 1'b1;
                  state_q      <= StBus;
               end
            end
            StBus: begin
               // ack beats a simultaneous timeout
               if (wbm_ack_i) begin
                  cyc_q <= 1'b0;
                  if (we_q) begin
                     beats_q <= beats_q - LEN_W'(1);
                     adr_q   <= next_adr(adr_q);
                     if (last_beat) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                     end else begin
                        state_q      <= StWdata;
                        wdat_ready_q <= 1'b1;
                     end
                  end else begin
                     rdat_q       <= wbm_dat_i;
                     rdat_valid_q <= 1'b1;
                     state_q      <= StRdata;
                  end
               end else if (expire) begin
                  cyc_q   <= 1'b0;
                  beats_q <= '0;
                  state_q <= StIdle;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
               end
            end
            StRdata: begin
               if (rdat_ready) begin
                  rdat_valid_q <= 1'b0;
                  beats_q      <= beats_q - LEN_W'(1);
                  adr_q        <= next_adr(adr_q);
                  if (last_beat) begin
                     state_q <= StIdle;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= StBus;
                     cyc_q   <= 1'b1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign wdat_ready = wdat_ready_q;
   assign rdat_valid = rdat_valid_q;
   assign rdat       = rdat_q;
   assign done       = done_q;
   assign err        = err_q;
   assign wbm_cyc_o  = cyc_q;
   assign wbm_stb_o  = cyc_q;
   assign wbm_we_o   = we_q;
   assign wbm_sel_o  = sel_q;
   assign wbm_adr_o  = adr_q;
   assign wbm_dat_o  = dat_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: memory-backed Wishbone slave with random ack delay,
// word-array reference model, directed scenarios plus random write/read-back.
module tb_wb_cmd_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_adr;
   logic [7:0]  cmd_len;
   logic [3:0]  cmd_sel;
   logic        wdat_valid, wdat_ready;
   logic [31:0] wdat;
   logic        rdat_valid, rdat_ready;
   logic [31:0] rdat;
   logic        done, err;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o;
   logic        wbm_ack;
   logic [31:0] wbm_dat_i;

   int          checks = 0;
   int          errors = 0;
   logic        no_ack = 1'b0;
   int          stb_cycles = 0;
   int          cyc_pulses = 0;
   logic [31:0] adr_log[$];
   logic [31:0] mem[256];
   logic [31:0] ref_mem[256];
   logic [31:0] wr_q[$];
   logic [31:0] rd_q[$];

   always #5 clk = ~clk;

   wb_cmd_master #(
      .TIMEOUT_CYCLES(16),
      .LEN_W         (8)
   ) dut (
      .wb_clk_i  (clk),
      .wb_rst_n_i(rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_we    (cmd_we),
      .cmd_adr   (cmd_adr),
      .cmd_len   (cmd_len),
      .cmd_sel   (cmd_sel),
      .wdat_valid(wdat_valid),
      .wdat_ready(wdat_ready),
      .wdat      (wdat),
      .rdat_valid(rdat_valid),
      .rdat_ready(rdat_ready),
      .rdat      (rdat),
      .done      (done),
      .err       (err),
      .wbm_cyc_o (wbm_cyc_o),
      .wbm_stb_o (wbm_stb_o),
      .wbm_we_o  (wbm_we_o),
      .wbm_sel_o (wbm_sel_o),
      .wbm_adr_o (wbm_adr_o),
      .wbm_dat_o (wbm_dat_o),
      .wbm_ack_i (wbm_ack),
      .wbm_dat_i (wbm_dat_i)
   );

   // Power-on contents: CSR words at the bottom, a recognisable pattern elsewhere
   function automatic logic [31:0] init_val(input int i);
      case (i)
         0:       return 32'h5E00_00FB;
         1:       return 32'h0000_0100;
         2:       return 32'hE000_00FB;
         3:       return 32'h0000_1F90;
         default: return 32'hC0DE_0000 | 32'(i);
      endcase
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   // Slave: 256-word memory mirrored every 1 KiB, registered ack after 0..3 wait cycles
   initial begin
      int          dly;
      logic        cyc_prev;
      logic [7:0]  idx;
      for (int i = 0; i < 256; i++) mem[i] = init_val(i);
      wbm_ack   = 1'b0;
      wbm_dat_i = '0;
      dly       = 0;
      cyc_prev  = 1'b0;
      forever begin
         @(posedge clk);
         if (wbm_cyc_o && wbm_stb_o) stb_cycles++;
         if (wbm_cyc_o && !cyc_prev) cyc_pulses++;
         cyc_prev = wbm_cyc_o;
         if (wbm_ack) begin
            wbm_ack <= 1'b0;
         end else if (wbm_cyc_o && wbm_stb_o && !no_ack) begin
            if (dly == 0) begin
               idx = wbm_adr_o[9:2];
               adr_log.push_back(wbm_adr_o);
               if (wbm_we_o) mem[idx] = merge(mem[idx], wbm_dat_o, wbm_sel_o);
               else wbm_dat_i <= mem[idx];
               wbm_ack <= 1'b1;
               dly = $urandom_range(0, 3);
            end else begin
               dly--;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Drive one command to completion; lat = cycles from accept edge to done sample
   task automatic run_cmd(input logic we, input logic [31:0] adr, input int len,
                          input logic [3:0] sel, input int stall_beat,
                          output logic got_done, output logic got_err, output int lat,
                          output logic bad_stall);
      int          cycles, wi, stall_left;
      logic        ctake, wtake, rtake, accepted, stalled;
      logic [31:0] held;
      rd_q.delete();
      wi = 0; cycles = 0; stall_left = 0; lat = -1; held = '0;
      accepted = 1'b0; stalled = 1'b0; got_done = 1'b0; got_err = 1'b0; bad_stall = 1'b0;
      cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = 8'(len); cmd_sel = sel;
      wdat_valid = 1'b0; rdat_ready = 1'b0;
      while (cycles < 2000) begin
         ctake = cmd_valid && cmd_ready;
         wtake = wdat_valid && wdat_ready;
         rtake = rdat_valid && rdat_ready;
         if (rtake) rd_q.push_back(rdat);
         @(posedge clk); #1;
         cycles++;
         if (ctake) begin
            cmd_valid = 1'b0;
            accepted  = 1'b1;
            lat       = 0;
         end else if (accepted) begin
            lat++;
         end
         if (wtake) wi++;
         if (done) begin
            got_done = 1'b1;
            got_err  = err;
            break;
         end
         wdat_valid = (wi < wr_q.size()) && ($urandom_range(0, 3) != 0);
         if (wi < wr_q.size()) wdat = wr_q[wi];
         if (stall_left > 0) begin
            if (rdat !== held || wbm_cyc_o !== 1'b0 || rdat_valid !== 1'b1) bad_stall = 1'b1;
            stall_left--;
            rdat_ready = 1'b0;
         end else if (!stalled && rdat_valid && (rd_q.size() == stall_beat)) begin
            stalled    = 1'b1;
            held       = rdat;
            stall_left = 9;
            rdat_ready = 1'b0;
         end else begin
            rdat_ready = ($urandom_range(0, 2) != 0);
         end
      end
      cmd_valid = 1'b0; wdat_valid = 1'b0; rdat_ready = 1'b0;
   endtask

   // Run a command and check it against the reference memory
   task automatic do_cmd(input logic we, input logic [31:0] adr, input int len,
                         input logic [3:0] sel, input int stall_beat, input string tag);
      int          n0, p0, lat;
      logic        dn, e, bad;
      logic [31:0] a;
      n0 = adr_log.size();
      p0 = cyc_pulses;
      if (we) begin
         wr_q.delete();
         for (int i = 0; i < len; i++) wr_q.push_back($urandom);
      end
      run_cmd(we, adr, len, sel, stall_beat, dn, e, lat, bad);
      check_bit({tag, "_done"}, dn, 1'b1);
      check_bit({tag, "_err"}, e, 1'b0);
      check_bit({tag, "_stall"}, bad, 1'b0);
      check({tag, "_nbeats"}, 32'(adr_log.size() - n0), 32'(len));
      check({tag, "_cycpulses"}, 32'(cyc_pulses - p0), 32'(len));
      if (!we) check({tag, "_nrd"}, 32'(rd_q.size()), 32'(len));
      for (int i = 0; i < len; i++) begin
         a = adr + 32'(4 * i);
         if (n0 + i < adr_log.size()) check($sformatf("%s_adr%0d", tag, i), adr_log[n0 + i], a);
         if (we) ref_mem[a[9:2]] = merge(ref_mem[a[9:2]], wr_q[i], sel);
         else if (i < rd_q.size())
            check($sformatf("%s_rd%0d", tag, i), rd_q[i], ref_mem[a[9:2]]);
      end
      wr_q.delete();
   endtask

   initial begin
      int          lat, s0, n, base;
      logic        dn, e, bad, ctake;
      logic [31:0] a;
      int          len;
      logic [3:0]  sel;
      cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_len = '0; cmd_sel = '0;
      wdat_valid = 1'b0; wdat = '0; rdat_ready = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_bit("rst_cyc", wbm_cyc_o, 1'b0);
      check_bit("rst_stb", wbm_stb_o, 1'b0);
      check_bit("rst_cmd_ready", cmd_ready, 1'b0);
      check_bit("rst_done", done, 1'b0);
      check_bit("rst_rdat_valid", rdat_valid, 1'b0);
      check_bit("rst_wdat_ready", wdat_ready, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_bit("idle_ready", cmd_ready, 1'b1);

      // CSR burst read with a 10-cycle consumer stall on the second beat
      do_cmd(1'b0, 32'h3000_0000, 4, 4'hF, 1, "csr_rd4");

      // Single write then read-back
      wr_q.delete();
      wr_q.push_back(32'hDEAD_BEEF);
      run_cmd(1'b1, 32'h3000_0000, 1, 4'hF, -1, dn, e, lat, bad);
      check_bit("wr1_done", dn, 1'b1);
      check_bit("wr1_err", e, 1'b0);
      ref_mem[0] = 32'hDEAD_BEEF;
      wr_q.delete();
      do_cmd(1'b0, 32'h3000_0000, 1, 4'hF, -1, "rd1");
      check("rd1_value", rd_q.size() > 0 ? rd_q[0] : 32'hx, 32'hDEAD_BEEF);

      // Zero-length command: done right after accept, no bus activity, one-cycle pulse
      s0 = stb_cycles;
      run_cmd(1'b0, 32'h3000_0010, 0, 4'hF, -1, dn, e, lat, bad);
      check_bit("len0_done", dn, 1'b1);
      check("len0_latency", 32'(lat), 32'd0);
      check("len0_stb", 32'(stb_cycles - s0), 32'd0);
      check_bit("len0_ready_in_done", cmd_ready, 1'b0);
      @(posedge clk); #1;
      check_bit("len0_done_pulse", done, 1'b0);
      check_bit("len0_ready_after", cmd_ready, 1'b1);

      // Address wrap across 2**32
      do_cmd(1'b1, 32'hFFFF_FFFC, 2, 4'hF, -1, "wrap_wr");
      do_cmd(1'b0, 32'hFFFF_FFFC, 2, 4'hF, -1, "wrap_rd");

      // Timeout: slave never acks
      no_ack = 1'b1;
      s0 = stb_cycles;
      run_cmd(1'b0, 32'h3000_0020, 3, 4'hF, -1, dn, e, lat, bad);
      check_bit("to_done", dn, 1'b1);
      check_bit("to_err", e, 1'b1);
      check("to_stb_cycles", 32'(stb_cycles - s0), 32'd16);
      check("to_no_rdat", 32'(rd_q.size()), 32'd0);
      no_ack = 1'b0;
      @(posedge clk); #1;
      check_bit("to_err_pulse", err, 1'b0);
      check_bit("to_idle_ready", cmd_ready, 1'b1);

      // Random write / read-back pairs with random byte lanes
      for (int k = 0; k < 6; k++) begin
         a   = 32'h3000_0100 + 32'(4 * $urandom_range(0, 40));
         len = $urandom_range(1, 5);
         sel = 4'($urandom_range(1, 15));
         do_cmd(1'b1, a, len, sel, -1, $sformatf("rnd%0d_wr", k));
         do_cmd(1'b0, a, len, 4'hF, $urandom_range(0, 1) == 0 ? -1 : 0,
                $sformatf("rnd%0d_rd", k));
      end

      // Reset asserted during the bus phase of beat 2 of 4
      base = adr_log.size();
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0000; cmd_len = 8'd4;
      cmd_sel = 4'hF; rdat_ready = 1'b1;
      n = 0;
      while (!(adr_log.size() == base + 1 && wbm_cyc_o && !wbm_ack) && n < 500) begin
         ctake = cmd_valid && cmd_ready;
         @(posedge clk); #1;
         if (ctake) cmd_valid = 1'b0;
         n++;
      end
      check_bit("mrst_reached_beat2", n < 500, 1'b1);
      cmd_valid = 1'b0; rdat_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_bit("mrst_cyc", wbm_cyc_o, 1'b0);
      check_bit("mrst_stb", wbm_stb_o, 1'b0);
      check_bit("mrst_done", done, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      do_cmd(1'b0, 32'h3000_0004, 2, 4'hF, -1, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
